// File: rtl/mem_array_sweep_if.sv
// mem_array_sweep_if
// Request/response bundle for the mem_array_sweep single-port array.
//   master: drives en, rw_bar, addr, data_in, clr; observes ready, rd_valid, data_out, busy
//   slave : the array side; observes the request fields and drives the status/read outputs
interface mem_array_sweep_if #(
    parameter int DATA_W = 3,
    parameter int ADDR_W = 2
) ();
    logic              en;
    logic              rw_bar;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic              clr;
    logic              ready;
    logic              rd_valid;
    logic [DATA_W-1:0] data_out;
    logic              busy;

    modport master (
        output en, rw_bar, addr, data_in, clr,
        input  ready, rd_valid, data_out, busy
    );

    modport slave (
        input  en, rw_bar, addr, data_in, clr,
        output ready, rd_valid, data_out, busy
    );
endinterface

// File: rtl/mem_array_sweep.sv
// mem_array_sweep
// Single-port DATA_W x 2**ADDR_W memory array with a registered read path,
// a ready handshake and a hardware clear sequencer that zeroes every row
// after reset or when clr is pulsed.
// Ports:
//   clk  - single clock, all state changes on the rising edge
//   rst  - synchronous active-high reset
//   bus  - mem_array_sweep_if.slave: en/rw_bar/addr/data_in/clr requests in,
//          ready/rd_valid/data_out/busy registered status and read data out
module mem_array_sweep #(
    parameter int DATA_W = 3,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    mem_array_sweep_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_LAST = '1;

    typedef enum logic {
        SWEEP,
        RUN
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic              ready_q;
    logic              busy_q;
    logic              rd_valid_q;
    logic [DATA_W-1:0] data_out_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic              accept;

    // A request only counts in RUN with ready up; clr takes precedence and
    // drops any request presented in the same cycle.
    assign accept = (state == RUN) && ready_q && bus.en && !bus.clr;

    // Single write port shared between the clear sweep and user writes.
    // Reset blocks both so a reset edge never disturbs the array.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = bus.addr;
        wr_data = bus.data_in;
        if (!rst) begin
            if (state == SWEEP) begin
                wr_en   = 1'b1;
                wr_addr = ptr;
                wr_data = '0;
            end else if (accept && bus.rw_bar) begin
                wr_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Control FSM. data_out is forced to zero on every cycle that does not
    // carry a read result, so rd_valid and data_out default low each edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SWEEP;
            ptr        <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            rd_valid_q <= 1'b0;
            data_out_q <= '0;
        end else begin
            rd_valid_q <= 1'b0;
            data_out_q <= '0;
            case (state)
                SWEEP: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == PTR_LAST) begin
                        state   <= RUN;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                RUN: begin
                    if (bus.clr) begin
                        state   <= SWEEP;
                        ptr     <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end else if (accept && !bus.rw_bar) begin
                        rd_valid_q <= 1'b1;
                        data_out_q <= mem[bus.addr];
                    end
                end
                default: begin
                    state <= SWEEP;
                    ptr   <= '0;
                end
            endcase
        end
    end

    assign bus.ready    = ready_q;
    assign bus.busy     = busy_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_mem_array_sweep.sv
// tb_mem_array_sweep
// Self-checking bench for mem_array_sweep with default parameters (3-bit
// words, 4 rows). Inputs change on the falling edge and outputs are sampled
// on the falling edge after the rising edge that produced them. Expected
// read data comes from a bench-side model of the array and is queued when a
// read is issued, then popped when the read result is sampled.
module tb_mem_array_sweep;
    localparam int DATA_W = 3;
    localparam int ADDR_W = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk;
    logic rst;

    mem_array_sweep_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    mem_array_sweep #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] model_mem [DEPTH];
    logic [DATA_W-1:0] exp_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends even if something stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic drive_idle();
        bus.en      = 1'b0;
        bus.rw_bar  = 1'b0;
        bus.addr    = '0;
        bus.data_in = '0;
        bus.clr     = 1'b0;
    endtask

    // Reset held for two edges, then the initial sweep with a write request
    // held throughout that must be ignored.
    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.ready !== 1'b0 || bus.busy !== 1'b1 || bus.rd_valid !== 1'b0 || bus.data_out !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_state: ready=%b busy=%b rd_valid=%b data_out=%b, required 0 1 0 000",
                     bus.ready, bus.busy, bus.rd_valid, bus.data_out);
        end
        rst         = 1'b0;
        bus.en      = 1'b1;
        bus.rw_bar  = 1'b1;
        bus.addr    = 2'd0;
        bus.data_in = 3'b111;
        for (int k = 1; k <= DEPTH; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus.ready !== (k == DEPTH) || bus.busy !== (k != DEPTH) || bus.rd_valid !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL reset_sweep edge %0d: ready=%b busy=%b rd_valid=%b, required ready=%b busy=%b rd_valid=0",
                         k, bus.ready, bus.busy, bus.rd_valid, k == DEPTH, k != DEPTH);
            end
        end
        drive_idle();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    endtask

    // Back-to-back reads of every row, compared against the model.
    task automatic test_read_rows(input string name);
        logic [DATA_W-1:0] exp;
        for (int i = 0; i < DEPTH; i++) begin
            bus.en     = 1'b1;
            bus.rw_bar = 1'b0;
            bus.addr   = ADDR_W'(i);
            exp_q.push_back(model_mem[i]);
            @(negedge clk);
            n_checks++;
            if (bus.rd_valid !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL %s row %0d: rd_valid=%b, required 1", name, i, bus.rd_valid);
            end else if (exp_q.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL %s row %0d: rd_valid with empty scoreboard", name, i);
            end else begin
                exp = exp_q.pop_front();
                if (bus.data_out !== exp) begin
                    n_fail++;
                    $display("[TB] FAIL %s row %0d: data_out=%b, required %b", name, i, bus.data_out, exp);
                end
            end
        end
        drive_idle();
        @(negedge clk);
        n_checks++;
        if (bus.rd_valid !== 1'b0 || bus.data_out !== '0) begin
            n_fail++;
            $display("[TB] FAIL %s idle: rd_valid=%b data_out=%b, required 0 000", name, bus.rd_valid, bus.data_out);
        end
        exp_q.delete();
    endtask

    // Writes every row; writes must not produce any output activity.
    task automatic test_write_rows();
        logic [DATA_W-1:0] vals [DEPTH];
        vals[0] = 3'b101;
        vals[1] = 3'b110;
        vals[2] = 3'b011;
        vals[3] = 3'b000;
        for (int i = 0; i < DEPTH; i++) begin
            bus.en      = 1'b1;
            bus.rw_bar  = 1'b1;
            bus.addr    = ADDR_W'(i);
            bus.data_in = vals[i];
            model_mem[i] = vals[i];
            @(negedge clk);
            n_checks++;
            if (bus.rd_valid !== 1'b0 || bus.data_out !== '0 || bus.ready !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL write_rows row %0d: rd_valid=%b data_out=%b ready=%b, required 0 000 1",
                         i, bus.rd_valid, bus.data_out, bus.ready);
            end
        end
        drive_idle();
    endtask

    // Read issued on the edge right after the write to the same row.
    task automatic test_read_after_write();
        logic [DATA_W-1:0] exp;
        bus.en      = 1'b1;
        bus.rw_bar  = 1'b1;
        bus.addr    = 2'd2;
        bus.data_in = 3'b111;
        model_mem[2] = 3'b111;
        @(negedge clk);
        bus.rw_bar = 1'b0;
        exp_q.push_back(model_mem[2]);
        @(negedge clk);
        drive_idle();
        n_checks++;
        if (bus.rd_valid !== 1'b1 || exp_q.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL raw_valid: rd_valid=%b, required 1", bus.rd_valid);
        end else begin
            exp = exp_q.pop_front();
            if (bus.data_out !== exp) begin
                n_fail++;
                $display("[TB] FAIL raw_data: data_out=%b, required %b", bus.data_out, exp);
            end
        end
        exp_q.delete();
        @(negedge clk);
    endtask

    // Read on one cycle, clr with a write request on the next.
    task automatic test_clear_pending();
        logic [DATA_W-1:0] exp;
        bus.en     = 1'b1;
        bus.rw_bar = 1'b0;
        bus.addr   = 2'd1;
        exp_q.push_back(model_mem[1]);
        @(negedge clk);
        n_checks++;
        if (bus.rd_valid !== 1'b1 || exp_q.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL clr_pending_valid: rd_valid=%b, required 1", bus.rd_valid);
        end else begin
            exp = exp_q.pop_front();
            if (bus.data_out !== exp) begin
                n_fail++;
                $display("[TB] FAIL clr_pending_data: data_out=%b, required %b", bus.data_out, exp);
            end
        end
        bus.clr     = 1'b1;
        bus.en      = 1'b1;
        bus.rw_bar  = 1'b1;
        bus.addr    = 2'd3;
        bus.data_in = 3'b010;
        @(negedge clk);
        drive_idle();
        n_checks++;
        if (bus.ready !== 1'b0 || bus.busy !== 1'b1 || bus.rd_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL clr_enter: ready=%b busy=%b rd_valid=%b, required 0 1 0",
                     bus.ready, bus.busy, bus.rd_valid);
        end
        for (int k = 1; k <= DEPTH; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus.ready !== (k == DEPTH) || bus.busy !== (k != DEPTH) || bus.rd_valid !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL clr_sweep edge %0d: ready=%b busy=%b rd_valid=%b, required ready=%b",
                         k, bus.ready, bus.busy, bus.rd_valid, k == DEPTH);
            end
        end
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        exp_q.delete();
    endtask

    // Reset applied while the sweep pointer is at row 2.
    task automatic test_reset_mid_sweep();
        for (int i = 0; i < DEPTH; i++) begin
            bus.en      = 1'b1;
            bus.rw_bar  = 1'b1;
            bus.addr    = ADDR_W'(i);
            bus.data_in = 3'b100 | DATA_W'(i);
            @(negedge clk);
        end
        bus.clr = 1'b1;
        bus.en  = 1'b0;
        @(negedge clk);
        bus.clr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (bus.ready !== 1'b0 || bus.busy !== 1'b1 || bus.rd_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL midsweep_reset: ready=%b busy=%b rd_valid=%b, required 0 1 0",
                     bus.ready, bus.busy, bus.rd_valid);
        end
        for (int k = 1; k <= DEPTH; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus.ready !== (k == DEPTH) || bus.rd_valid !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL midsweep_sweep edge %0d: ready=%b rd_valid=%b, required ready=%b rd_valid=0",
                         k, bus.ready, bus.rd_valid, k == DEPTH);
            end
        end
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        test_reset();
        test_read_rows("reset_sweep_reads");
        test_write_rows();
        test_read_rows("write_read_all");
        test_clear_pending();
        test_read_rows("after_clear_reads");
        test_read_after_write();
        test_reset_mid_sweep();
        test_read_rows("after_midsweep_reads");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_array_sweep.md
# mem_array_sweep

Parametrised single-port memory array with a DATA_W-bit word and 2**ADDR_W rows. It replaces the fixed 4x3 binary-cell array and keeps the same `rw_bar` write/read convention and zero-when-idle output. It adds three things the fixed array lacks: a registered read path with a valid strobe, a ready handshake, and a hardware clear sequencer that zeroes every row after reset or on request. It sits between the row-level control logic and any consumer that needs deterministic initial contents.

## Interface

Parameters:
- `DATA_W`, default 3: word width in bits (≥1).
- `ADDR_W`, default 2: row address width; DEPTH = 2**ADDR_W rows (ADDR_W ≥1).

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `en`, input, 1: request valid (global enable).
- `rw_bar`, input, 1: 1 = write, 0 = read; sampled with `en`.
- `addr`, input, ADDR_W: row select.
- `data_in`, input, DATA_W: write data.
- `clr`, input, 1: start a clear sweep (level-sampled, single-cycle pulse expected).
- `ready`, output, 1: registered; 1 = requests are accepted this cycle.
- `rd_valid`, output, 1: registered; 1-cycle pulse when `data_out` carries read data.
- `data_out`, output, DATA_W: registered read data; all zeros whenever `rd_valid` = 0.
- `busy`, output, 1: registered; 1 while the clear sweep runs (equals ~`ready`).

## Operation

- Two-state FSM: SWEEP, RUN. Sweep pointer `ptr` is ADDR_W bits.
- Reset: state = SWEEP, ptr = 0, ready = 0, busy = 1, rd_valid = 0, data_out = 0. Array contents are undefined until the sweep completes.
- SWEEP:
  - Each cycle writes mem[ptr] = 0 and increments ptr.
  - On the cycle that writes row DEPTH-1, go to RUN and set ready = 1 and busy = 0. ptr wraps to 0.
  - `en` is ignored in SWEEP. `clr` in SWEEP is ignored; the sweep does not restart.
- RUN, request accepted when `en & ready & ~clr`:
  - Write (rw_bar = 1): mem[addr] = data_in at that edge. No output change.
  - Read (rw_bar = 0): next cycle data_out = mem[addr], rd_valid = 1. The cycle after that, data_out = 0 and rd_valid = 0 unless another read was accepted.
- RUN with `clr` = 1: go to SWEEP, ptr = 0, ready = 0 and busy = 1 from the next cycle. Any `en` in the same cycle is dropped.
- A read accepted in the cycle before `clr` still completes: rd_valid pulses with the pre-clear data.
- Only one operation per cycle (single port). Read-after-write to the same row on the next cycle returns the new data.
- Unaccepted cycles (`en` = 0, or ready = 0) leave the array unchanged and produce no rd_valid.

## Timing

- Sweep length: exactly DEPTH cycles.
  - `ready` rises after the DEPTH-th rising edge with rst = 0.
  - With DEPTH = 4: rst released before edge 1; rows 0..3 are written at edges 1..4; ready = 1 after edge 4.
- Read latency: 1 cycle from the accepting edge to rd_valid/data_out. Back-to-back reads give continuous rd_valid at a throughput of one read per cycle.
- Write latency: the data is visible to a read accepted on the very next edge.
- `clr` to ready: DEPTH+1 edges. This is 1 edge to enter SWEEP plus DEPTH sweep edges.
- `rst` asserted in any state, including mid-sweep or with a read pending, at the next edge:
  - all outputs return to their reset values;
  - the pending rd_valid is cancelled;
  - the sweep restarts at row 0.
- `rst` has priority over `clr` and `en`. `clr` has priority over `en`.

## Test plan

- **Reset sweep:** defaults, hold rst 2 cycles then release. Require ready = 0 for 4 edges, then ready = 1 and busy = 0. Reads of rows 0..3 return 000 with rd_valid pulses.
- **Write/read all rows:** write rows 0..3 = 101, 110, 011, 000. Then issue back-to-back reads 0..3. Require rd_valid high for 4 consecutive cycles with data_out = 101, 110, 011, 000, then 000 and rd_valid = 0.
- **Read-after-write:** write row 2 = 111, then read row 2 on the next cycle. Require data_out = 111 one cycle later.
- **Clear with read pending:** after the write/read-all-rows test, read row 1, then pulse clr on the next cycle with `en` = 1 for a write to row 3 = 010.
  - Require rd_valid with 110.
  - Require the write dropped and ready low for 4 cycles.
  - All rows then read 000.
- **Reset mid-sweep:** assert rst for 1 cycle at sweep row 2. Require a full 4-cycle sweep after release, and no rd_valid during it.
- **Ignored requests:** during the sweep, drive en = 1 with a write to row 0 = 111. After ready rises, row 0 reads 000.
